// File: rtl/mem_resp_mc_if.sv
// Request/response bundle between the control unit and the memory responder.
// The master issues strobes; the slave answers with ready/err/rdata/busy.
interface mem_resp_mc_if;
    logic        i_d_mem;
    logic        mem_r;
    logic        mem_w;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    modport master (
        output i_d_mem, mem_r, mem_w, mem_size, mem_unsigned, addr, wdata,
        input  rdata, ready, err, busy
    );

    modport slave (
        input  i_d_mem, mem_r, mem_w, mem_size, mem_unsigned, addr, wdata,
        output rdata, ready, err, busy
    );
endinterface

// File: rtl/mem_resp_mc.sv
// Latency-modelled unified instruction/data memory for the multi-cycle core.
// Illegal accesses complete with err=1 and leave the array untouched.
module mem_resp_mc #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256,
    parameter int LATENCY    = 2
) (
    input logic          clk,
    input logic          rst,
    mem_resp_mc_if.slave bus
);
    localparam int WORDS = IMEM_WORDS + DMEM_WORDS;
    localparam int IW    = $clog2(WORDS);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
    localparam logic [31:0] ILIM = 32'(IMEM_WORDS);
    localparam logic [31:0] DLIM = 32'(DMEM_WORDS);

    logic [31:0] mem [WORDS];

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        q_dsel, q_r, q_w, q_uns;
    logic [1:0]  q_size;
    logic [31:0] q_addr, q_wdata;
    logic [31:0] rdata_q;
    logic        ready_q, err_q, busy_q;

    logic          req, live, enter_resp;
    logic          dsel, rd, wr, uns, fetch, euns;
    logic [1:0]    size, esize;
    logic [31:0]   a, wd, word, sh, ld, wmerge;
    logic [3:0]    be;
    logic          oob, mis, bad;
    logic [IW-1:0] idx;

    assign req  = bus.mem_r | bus.mem_w;
    assign live = (state == IDLE);

    // Decode from the live bus when sampling, so LATENCY=1 can commit at once.
    always_comb begin
        dsel  = live ? bus.i_d_mem      : q_dsel;
        rd    = live ? bus.mem_r        : q_r;
        wr    = live ? bus.mem_w        : q_w;
        size  = live ? bus.mem_size     : q_size;
        uns   = live ? bus.mem_unsigned : q_uns;
        a     = live ? bus.addr         : q_addr;
        wd    = live ? bus.wdata        : q_wdata;
        fetch = !dsel && rd;
        esize = fetch ? 2'b10 : size;
        euns  = uns && !fetch;
        oob   = {2'b00, a[31:2]} >= (dsel ? DLIM : ILIM);
        mis   = (esize == 2'b01 && a[0]) ||
                (esize == 2'b10 && a[1:0] != 2'b00);
        bad   = (rd && wr) || (wr && !dsel) ||
                esize == 2'b11 || mis || oob;
        idx   = IW'(a[31:2]) + (dsel ? IW'(IMEM_WORDS) : '0);
        word  = mem[idx];
        sh    = word >> {a[1:0], 3'b000};
        ld     = '0;
        be     = '0;
        wmerge = '0;
        unique case (1'b1)
            esize == 2'b00: begin
                ld     = {{24{!euns && sh[7]}}, sh[7:0]};
                be     = 4'b0001 << a[1:0];
                wmerge = {4{wd[7:0]}};
            end
            esize == 2'b01: begin
                ld     = {{16{!euns && sh[15]}}, sh[15:0]};
                be     = a[1] ? 4'b1100 : 4'b0011;
                wmerge = {2{wd[15:0]}};
            end
            esize == 2'b10: begin
                ld     = word;
                be     = 4'b1111;
                wmerge = wd;
            end
            default: ld = '0;
        endcase
    end

    assign enter_resp = (live && req && LATENCY == 1) ||
                        (state == WAIT && cnt == 4'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ready_q <= enter_resp;
            err_q   <= enter_resp && bad;
            if (enter_resp)
                rdata_q <= (bad || wr) ? '0 : ld;
            unique case (state)
                IDLE: if (req) begin
                    q_dsel  <= bus.i_d_mem;
                    q_r     <= bus.mem_r;
                    q_w     <= bus.mem_w;
                    q_size  <= bus.mem_size;
                    q_uns   <= bus.mem_unsigned;
                    q_addr  <= bus.addr;
                    q_wdata <= bus.wdata;
                    cnt     <= CNT_INIT;
                    state   <= (LATENCY == 1) ? RESP : WAIT;
                    busy_q  <= 1'b1;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= RESP;
                end
                RESP: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && enter_resp && wr && !bad) begin
            for (int i = 0; i < 4; i++)
                if (be[i])
                    mem[idx][8*i +: 8] <= wmerge[8*i +: 8];
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;
endmodule

// File: doc/mem_resp_mc.md
Name: mem_resp_mc

Overview:
- Memory-side responder for the multi-cycle RISC-V core.
- Services the control unit's memory strobes: mem_r, mem_w, i_d_mem and mem_size.
- Holds a unified word array split into an instruction region and a data region.
- Models a configurable access latency, returns aligned and sign/zero-extended load data, and performs byte/half/word stores with byte enables.
- Flags illegal accesses instead of corrupting memory.

Parameters:
- IMEM_WORDS, 256: words in the instruction region (i_d_mem=0).
- DMEM_WORDS, 256: words in the data region (i_d_mem=1).
- LATENCY, 2: cycles from request sample to ready; legal range 1..15.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- i_d_mem, input, 1: region select; 0 = instruction fetch, 1 = data access.
- mem_r, input, 1: read request strobe.
- mem_w, input, 1: write request strobe.
- mem_size, input, 2: 00 byte, 01 half, 10 word, 11 illegal.
- mem_unsigned, input, 1: load zero-extend (funct3[2]); ignored for stores and fetches.
- addr, input, 32: byte address within the selected region.
- wdata, input, 32: store data, right-aligned.
- rdata, output, 32: load/fetch data, extended to 32 bits.
- ready, output, 1: one-cycle completion pulse.
- err, output, 1: error qualifier, valid only while ready=1.
- busy, output, 1: high from request sample until the ready cycle, inclusive.

Behaviour:
- Reset values: rdata=0, ready=0, err=0, busy=0, state=IDLE, latency counter=0. Array contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Samples a request on an edge where mem_r|mem_w=1.
  - Latches i_d_mem, mem_r, mem_w, mem_size, mem_unsigned, addr and wdata.
  - Loads the counter with LATENCY-1 and goes to WAIT; if LATENCY=1, goes straight to RESP.
  - Sets busy=1.
- WAIT: decrements the counter each cycle; moves to RESP when the counter reaches 0.
- RESP:
  - ready=1 for exactly one cycle, and rdata/err are valid in that cycle.
  - Returns to IDLE on the next edge.
  - ready therefore rises LATENCY cycles after the sampling edge.
  - A request that is high in this same cycle is NOT sampled; back-to-back throughput is one access per LATENCY+1 cycles.
- Requests arriving while in WAIT or RESP are ignored; no queueing.
- Fetch (i_d_mem=0, mem_r=1):
  - mem_size is forced to word and mem_unsigned is ignored.
  - Word index = addr[31:2].
- Data access word index = IMEM_WORDS + addr[31:2].
- err=1 in the RESP cycle when any of the following hold; no array write occurs and rdata=0:
  - mem_r and mem_w are both 1 at sample.
  - mem_w=1 with i_d_mem=0 (writes to the instruction region are forbidden).
  - mem_size=11.
  - Misalignment: half access with addr[0]=1, or word access with addr[1:0]!=00.
  - Word index beyond the region: addr[31:2] >= IMEM_WORDS for fetches, >= DMEM_WORDS for data accesses.
- Little-endian load data:
  - byte = word[8*addr[1:0] +: 8];
  - half = word[16*addr[1] +: 16];
  - sign-extended unless mem_unsigned=1.
- Store data:
  - byte writes wdata[7:0] into lane addr[1:0];
  - half writes wdata[15:0] into lanes {addr[1],0} and {addr[1],1};
  - word writes all lanes.
  - Other lanes are preserved.
- A store commits on the edge that enters RESP, so a read issued afterwards sees the new data.
- rdata holds its value after ready falls until the next RESP; it is 0 for stores.
- Reset asserted mid-access: the access is aborted, no write commits, outputs return to reset values on that edge, and no ready is produced for the aborted request.

Test Plan:
- Preload data word 0 = 0x8899AABB. Issue data read, size=00, addr=3, mem_unsigned=0 -> ready exactly 2 cycles after sample, rdata=0xFFFFFF88, err=0. Repeat with mem_unsigned=1 -> rdata=0x00000088.
- Store half wdata=0x1234ABCD at data addr=6, then word read at addr=4 with prior contents 0x00000000 -> rdata=0xABCD0000; lanes 0-1 unchanged.
- Store at i_d_mem=0 addr=0 -> ready with err=1, instruction word 0 unchanged. Word read at addr=2 -> err=1, rdata=0. Request with mem_r=mem_w=1 -> err=1.
- LATENCY=1 build: fetch at addr=0x10 -> ready on the next cycle with instruction word 4. A request held high during RESP is ignored; a new request in the following IDLE cycle is sampled.
- Assert rst one cycle after sampling a word store 0xDEADBEEF to data addr 0 -> no ready. A subsequent read of data addr 0 returns the old value; busy=0 after the reset edge.
- Out of range: data read at addr=4*DMEM_WORDS -> err=1, rdata=0; the same index minus 4 reads normally.
